digit_border_reader: RTL and testbench

//  Reader side of the projection border RAMs. On each completed projection it fetches
//  row/column digit borders over the RAM read ports and assembles per-digit bounding boxes.

---
 rtl/digit_border_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_digit_border_reader.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_border_reader.sv
// digit_border_reader
//   Reader side of the projection border RAMs. When a projection completes, the
//   row borders and then the column borders are fetched over the RAM read ports,
//   clamped into the active area and held. Every (row, column) pair is then
//   streamed out as a bounding box over a valid/ready handshake. The held
//   borders also drive a pixel overlay flag for drawing the boxes on screen.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   project_done_flag             projection complete (level; rising edge starts a capture)
//   num_col, num_row              digit counts reported by the projection
//   col_border_addr_rd/data_rd    column border RAM read port (1-cycle read latency)
//   row_border_addr_rd/data_rd    row border RAM read port (1-cycle read latency)
//   box_valid/box_ready           box stream handshake
//   box_idx                       row-major box index r*ncol+c
//   box_left/right/top/bottom     inclusive box bounds
//   box_last                      final box of the capture
//   borders_valid                 held borders form a complete capture
//   busy                          capture or stream in progress
//   xpos, ypos                    display pixel coordinate
//   on_border                     pixel lies on a box edge (registered)
module digit_border_reader #(
  parameter int NUM_ROW = 1,
  parameter int NUM_COL = 4,
  parameter int H_PIXEL = 480,
  parameter int V_PIXEL = 272,
  parameter int DEPBIT  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              project_done_flag,
  input  logic [3:0]        num_col,
  input  logic [3:0]        num_row,
  output logic [DEPBIT-1:0] col_border_addr_rd,
  input  logic [DEPBIT-1:0] col_border_data_rd,
  output logic [DEPBIT-1:0] row_border_addr_rd,
  input  logic [DEPBIT-1:0] row_border_data_rd,
  output logic              box_valid,
  input  logic              box_ready,
  output logic [3:0]        box_idx,
  output logic [10:0]       box_left,
  output logic [10:0]       box_right,
  output logic [10:0]       box_top,
  output logic [10:0]       box_bottom,
  output logic              box_last,
  output logic              borders_valid,
  output logic              busy,
  input  logic [10:0]       xpos,
  input  logic [10:0]       ypos,
  output logic              on_border
);

  localparam logic [3:0]  NROW_MAX = 4'(NUM_ROW);
  localparam logic [3:0]  NCOL_MAX = 4'(NUM_COL);
  localparam logic [10:0] H_LIM    = 11'(H_PIXEL);
  localparam logic [10:0] V_LIM    = 11'(V_PIXEL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ROW = 2'd1,
    ST_RD_COL = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  // A start value at or beyond the active size is a wrapped (underflowed)
  // writer value, so it is pulled back to the first pixel.
  function automatic logic [10:0] clamp_start(input logic [10:0] val,
                                              input logic [10:0] lim);
    logic [10:0] res;
    if (val >= lim) res = 11'd0;
    else            res = val;
    return res;
  endfunction

  // An end value is saturated to the last pixel and never placed before its start.
  function automatic logic [10:0] clamp_end(input logic [10:0] val,
                                            input logic [10:0] lim,
                                            input logic [10:0] start);
    logic [10:0] res;
    if (val > (lim - 11'd1)) res = lim - 11'd1;
    else                     res = val;
    if (res < start) res = start;
    else             res = res;
    return res;
  endfunction

  // True when (x,y) lies on the outline of the inclusive box (l,r,t,b).
  function automatic logic edge_hit(input logic [10:0] x, input logic [10:0] y,
                                    input logic [10:0] l, input logic [10:0] r,
                                    input logic [10:0] t, input logic [10:0] b);
    logic vert_s;
    logic horz_s;
    vert_s = ((x == l) || (x == r)) && (y >= t) && (y <= b);
    horz_s = ((y == t) || (y == b)) && (x >= l) && (x <= r);
    return vert_s || horz_s;
  endfunction

  state_t            state_r, state_s;
  logic              done_d_r;
  logic              done_rise_s;
  logic [3:0]        nrow_r, ncol_r;
  logic [DEPBIT-1:0] row_lim_s, col_lim_s;
  logic [DEPBIT-1:0] issue_cnt_r;
  logic [DEPBIT-1:0] row_addr_r, col_addr_r;
  logic [DEPBIT-1:0] row_addr_d_r, col_addr_d_r;
  logic [10:0]       row_data_s, col_data_s;
  logic [10:0]       row_top_r   [NUM_ROW];
  logic [10:0]       row_bot_r   [NUM_ROW];
  logic [10:0]       col_left_r  [NUM_COL];
  logic [10:0]       col_right_r [NUM_COL];
  logic              borders_valid_r, busy_r;
  logic              box_valid_r, box_last_r;
  logic [3:0]        box_idx_r;
  logic [10:0]       box_left_r, box_right_r, box_top_r, box_bottom_r;
  logic [3:0]        emit_row_r, emit_col_r, emit_idx_r;
  logic [10:0]       sel_top_s, sel_bot_s, sel_left_s, sel_right_s;
  logic              sel_last_s;
  logic              xfer_s, load_s;
  logic              hit_s, on_border_r;

  assign done_rise_s = project_done_flag & ~done_d_r;
  // Each entry occupies two RAM words (start, end), so the last address is 2*n.
  assign row_lim_s   = DEPBIT'({nrow_r, 1'b0});
  assign col_lim_s   = DEPBIT'({ncol_r, 1'b0});
  assign row_data_s  = 11'(row_border_data_rd);
  assign col_data_s  = 11'(col_border_data_rd);
  assign xfer_s      = box_valid_r & box_ready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (done_rise_s) state_s = ST_RD_ROW;
        else             state_s = ST_IDLE;
      end
      ST_RD_ROW: begin
        // An empty grid ends the capture without touching the RAMs.
        if ((nrow_r == 4'd0) || (ncol_r == 4'd0)) state_s = ST_IDLE;
        else if (row_addr_d_r == row_lim_s)       state_s = ST_RD_COL;
        else                                      state_s = ST_RD_ROW;
      end
      ST_RD_COL: begin
        if (col_addr_d_r == col_lim_s) state_s = ST_EMIT;
        else                           state_s = ST_RD_COL;
      end
      ST_EMIT: begin
        if (xfer_s && box_last_r) state_s = ST_IDLE;
        else                      state_s = ST_EMIT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Capture control: edge detect, latched counts, busy and borders_valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_d_r        <= 1'b0;
      nrow_r          <= 4'd0;
      ncol_r          <= 4'd0;
      busy_r          <= 1'b0;
      borders_valid_r <= 1'b0;
    end else begin
      done_d_r <= project_done_flag;
      busy_r   <= (state_s != ST_IDLE);
      if ((state_r == ST_IDLE) && done_rise_s) begin
        nrow_r          <= (num_row > NROW_MAX) ? NROW_MAX : num_row;
        ncol_r          <= (num_col > NCOL_MAX) ? NCOL_MAX : num_col;
        borders_valid_r <= 1'b0;
      end else if ((state_r == ST_RD_COL) && (state_s == ST_EMIT)) begin
        borders_valid_r <= 1'b1;
      end
    end
  end

  // Read address sequencer; the delayed copy tags the data returning from the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r  <= '0;
      row_addr_r   <= '0;
      col_addr_r   <= '0;
      row_addr_d_r <= '0;
      col_addr_d_r <= '0;
    end else begin
      row_addr_d_r <= row_addr_r;
      col_addr_d_r <= col_addr_r;
      if (state_s != state_r) begin
        issue_cnt_r <= '0;
        row_addr_r  <= '0;
        col_addr_r  <= '0;
      end else if ((state_r == ST_RD_ROW) && (issue_cnt_r < row_lim_s)) begin
        issue_cnt_r <= issue_cnt_r + DEPBIT'(1'b1);
        row_addr_r  <= issue_cnt_r + DEPBIT'(1'b1);
        col_addr_r  <= '0;
      end else if ((state_r == ST_RD_COL) && (issue_cnt_r < col_lim_s)) begin
        issue_cnt_r <= issue_cnt_r + DEPBIT'(1'b1);
        col_addr_r  <= issue_cnt_r + DEPBIT'(1'b1);
        row_addr_r  <= '0;
      end else begin
        row_addr_r  <= '0;
        col_addr_r  <= '0;
      end
    end
  end

  // Border registers: odd address = start, even address = end of entry (addr-1)/2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ROW; k++) begin
        row_top_r[k] <= 11'd0;
        row_bot_r[k] <= 11'd0;
      end
      for (int k = 0; k < NUM_COL; k++) begin
        col_left_r[k]  <= 11'd0;
        col_right_r[k] <= 11'd0;
      end
    end else begin
      for (int k = 0; k < NUM_ROW; k++) begin
        if (row_addr_d_r == DEPBIT'(2 * k + 1))
          row_top_r[k] <= clamp_start(row_data_s, V_LIM);
        else if (row_addr_d_r == DEPBIT'(2 * k + 2))
          row_bot_r[k] <= clamp_end(row_data_s, V_LIM, row_top_r[k]);
      end
      for (int k = 0; k < NUM_COL; k++) begin
        if (col_addr_d_r == DEPBIT'(2 * k + 1))
          col_left_r[k] <= clamp_start(col_data_s, H_LIM);
        else if (col_addr_d_r == DEPBIT'(2 * k + 2))
          col_right_r[k] <= clamp_end(col_data_s, H_LIM, col_left_r[k]);
      end
    end
  end

  // Select the borders of the box at the current emit position.
  always_comb begin
    sel_top_s   = 11'd0;
    sel_bot_s   = 11'd0;
    sel_left_s  = 11'd0;
    sel_right_s = 11'd0;
    for (int r = 0; r < NUM_ROW; r++) begin
      if (4'(r) == emit_row_r) begin
        sel_top_s = row_top_r[r];
        sel_bot_s = row_bot_r[r];
      end else begin
        sel_top_s = sel_top_s;
        sel_bot_s = sel_bot_s;
      end
    end
    for (int c = 0; c < NUM_COL; c++) begin
      if (4'(c) == emit_col_r) begin
        sel_left_s  = col_left_r[c];
        sel_right_s = col_right_r[c];
      end else begin
        sel_left_s  = sel_left_s;
        sel_right_s = sel_right_s;
      end
    end
    sel_last_s = (emit_row_r == (nrow_r - 4'd1)) && (emit_col_r == (ncol_r - 4'd1));
  end

  // A new box is loaded when the output slot is empty or being drained,
  // except on the transfer of the final box.
  assign load_s = (state_r == ST_EMIT) && !(xfer_s && box_last_r) &&
                  (!box_valid_r || box_ready);

  // Box stream output registers and row-major emit counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_valid_r  <= 1'b0;
      box_last_r   <= 1'b0;
      box_idx_r    <= 4'd0;
      box_left_r   <= 11'd0;
      box_right_r  <= 11'd0;
      box_top_r    <= 11'd0;
      box_bottom_r <= 11'd0;
      emit_row_r   <= 4'd0;
      emit_col_r   <= 4'd0;
      emit_idx_r   <= 4'd0;
    end else if (state_r != ST_EMIT) begin
      box_valid_r <= 1'b0;
      box_last_r  <= 1'b0;
      emit_row_r  <= 4'd0;
      emit_col_r  <= 4'd0;
      emit_idx_r  <= 4'd0;
    end else if (xfer_s && box_last_r) begin
      box_valid_r <= 1'b0;
      box_last_r  <= 1'b0;
    end else if (load_s) begin
      box_valid_r  <= 1'b1;
      box_last_r   <= sel_last_s;
      box_idx_r    <= emit_idx_r;
      box_left_r   <= sel_left_s;
      box_right_r  <= sel_right_s;
      box_top_r    <= sel_top_s;
      box_bottom_r <= sel_bot_s;
      emit_idx_r   <= emit_idx_r + 4'd1;
      if (emit_col_r == (ncol_r - 4'd1)) begin
        emit_col_r <= 4'd0;
        emit_row_r <= emit_row_r + 4'd1;
      end else begin
        emit_col_r <= emit_col_r + 4'd1;
      end
    end
  end

  // Overlay hit test over the populated box slots only.
  always_comb begin
    hit_s = 1'b0;
    for (int r = 0; r < NUM_ROW; r++) begin
      for (int c = 0; c < NUM_COL; c++) begin
        if ((4'(r) < nrow_r) && (4'(c) < ncol_r) &&
            edge_hit(xpos, ypos, col_left_r[c], col_right_r[c], row_top_r[r], row_bot_r[r]))
          hit_s = 1'b1;
        else
          hit_s = hit_s;
      end
    end
  end

  // Registered overlay flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) on_border_r <= 1'b0;
    else        on_border_r <= borders_valid_r & hit_s;
  end

  assign col_border_addr_rd = col_addr_r;
  assign row_border_addr_rd = row_addr_r;
  assign box_valid          = box_valid_r;
  assign box_idx            = box_idx_r;
  assign box_left           = box_left_r;
  assign box_right          = box_right_r;
  assign box_top            = box_top_r;
  assign box_bottom         = box_bottom_r;
  assign box_last           = box_last_r;
  assign borders_valid      = borders_valid_r;
  assign busy               = busy_r;
  assign on_border          = on_border_r;

endmodule

// File: tb/tb_digit_border_reader.sv
module tb_digit_border_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        project_done_flag;
  logic [3:0]  num_col, num_row;
  logic [9:0]  col_border_addr_rd, col_border_data_rd;
  logic [9:0]  row_border_addr_rd, row_border_data_rd;
  logic        box_valid, box_ready, box_last, borders_valid, busy, on_border;
  logic [3:0]  box_idx;
  logic [10:0] box_left, box_right, box_top, box_bottom, xpos, ypos;

  logic [9:0]  row_mem [16];
  logic [9:0]  col_mem [16];
  int          col_rd_cnt = 0, col_addr_sum = 0, col_over = 0;
  int          row_rd_cnt = 0, row_addr_sum = 0;
  int          n_checks = 0, n_pass = 0;

  always #5 clk = ~clk;

  digit_border_reader dut (
    .clk(clk), .rst_n(rst_n), .project_done_flag(project_done_flag),
    .num_col(num_col), .num_row(num_row),
    .col_border_addr_rd(col_border_addr_rd), .col_border_data_rd(col_border_data_rd),
    .row_border_addr_rd(row_border_addr_rd), .row_border_data_rd(row_border_data_rd),
    .box_valid(box_valid), .box_ready(box_ready), .box_idx(box_idx),
    .box_left(box_left), .box_right(box_right), .box_top(box_top), .box_bottom(box_bottom),
    .box_last(box_last), .borders_valid(borders_valid), .busy(busy),
    .xpos(xpos), .ypos(ypos), .on_border(on_border)
  );

  // Border RAM models with one-cycle read latency.
  always @(posedge clk) begin
    row_border_data_rd <= row_mem[row_border_addr_rd[3:0]];
    col_border_data_rd <= col_mem[col_border_addr_rd[3:0]];
  end

  // Read-port activity monitor.
  always @(posedge clk) begin
    if (col_border_addr_rd != 10'd0) begin
      col_rd_cnt   <= col_rd_cnt + 1;
      col_addr_sum <= col_addr_sum + int'(col_border_addr_rd);
      if (col_border_addr_rd > 10'd8) col_over <= col_over + 1;
    end
    if (row_border_addr_rd != 10'd0) begin
      row_rd_cnt   <= row_rd_cnt + 1;
      row_addr_sum <= row_addr_sum + int'(row_border_addr_rd);
    end
  end

  task automatic pulse_done;
    @(posedge clk); #1 project_done_flag = 1'b1;
    @(posedge clk); #1 project_done_flag = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (box_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_std;
    row_mem[1] = 10'd20;  row_mem[2] = 10'd60;
    col_mem[1] = 10'd10;  col_mem[2] = 10'd50;
    col_mem[3] = 10'd70;  col_mem[4] = 10'd110;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({box_valid, box_last, borders_valid, busy, on_border} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000", {box_valid, box_last, borders_valid, busy, on_border});
    else n_pass++;
    n_checks++;
    if ({box_idx, box_left, box_right, box_top, box_bottom} !== 48'd0)
      $display("FAIL reset_box got %h exp 0", {box_idx, box_left, box_right, box_top, box_bottom});
    else n_pass++;
    n_checks++;
    if ({col_border_addr_rd, row_border_addr_rd} !== 20'd0)
      $display("FAIL reset_addr got %0d,%0d exp 0,0", col_border_addr_rd, row_border_addr_rd);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, box_valid, row_border_addr_rd} !== 12'd0)
      $display("FAIL idle_after_reset got busy=%b valid=%b raddr=%0d exp 0", busy, box_valid, row_border_addr_rd);
    else n_pass++;
  endtask

  task automatic test_capture;
    bit ok;
    int c0, s0, r0, rs0;
    box_ready = 1'b1; num_row = 4'd1; num_col = 4'd2;
    load_std();
    c0 = col_rd_cnt; s0 = col_addr_sum; r0 = row_rd_cnt; rs0 = row_addr_sum;
    pulse_done();
    @(negedge clk);
    n_checks++;
    if ({busy, borders_valid} !== 2'b10)
      $display("FAIL cap_busy got busy=%b bv=%b exp 1,0", busy, borders_valid);
    else n_pass++;
    wait_valid(ok);
    n_checks++;
    if (!ok) $display("FAIL cap_timeout got no box_valid exp box_valid within 100 cycles");
    else n_pass++;
    n_checks++;
    if ({box_idx, box_last, box_left, box_right, box_top, box_bottom, borders_valid} !==
        {4'd0, 1'b0, 11'd10, 11'd50, 11'd20, 11'd60, 1'b1})
      $display("FAIL cap_box0 got idx=%0d last=%b L=%0d R=%0d T=%0d B=%0d bv=%b exp 0,0,10,50,20,60,1",
               box_idx, box_last, box_left, box_right, box_top, box_bottom, borders_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({box_valid, box_idx, box_last, box_left, box_right, box_top, box_bottom} !==
        {1'b1, 4'd1, 1'b1, 11'd70, 11'd110, 11'd20, 11'd60})
      $display("FAIL cap_box1 got v=%b idx=%0d last=%b L=%0d R=%0d T=%0d B=%0d exp 1,1,1,70,110,20,60",
               box_valid, box_idx, box_last, box_left, box_right, box_top, box_bottom);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({box_valid, busy, borders_valid} !== 3'b001)
      $display("FAIL cap_end got v=%b busy=%b bv=%b exp 0,0,1", box_valid, busy, borders_valid);
    else n_pass++;
    n_checks++;
    if ((col_rd_cnt - c0 != 4) || (col_addr_sum - s0 != 10) || (row_rd_cnt - r0 != 2) || (row_addr_sum - rs0 != 3))
      $display("FAIL cap_reads got col=%0d/%0d row=%0d/%0d exp 4/10 2/3",
               col_rd_cnt - c0, col_addr_sum - s0, row_rd_cnt - r0, row_addr_sum - rs0);
    else n_pass++;
  endtask

  task automatic test_overlay;
    logic [10:0] xs [6] = '{11'd10, 11'd30, 11'd30, 11'd110, 11'd0, 11'd50};
    logic [10:0] ys [6] = '{11'd40, 11'd40, 11'd60, 11'd20, 11'd40, 11'd61};
    logic        ex [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 xpos = xs[i]; ypos = ys[i];
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (on_border !== ex[i])
        $display("FAIL overlay_%0d got %b exp %b at x=%0d y=%0d", i, on_border, ex[i], xs[i], ys[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall;
    bit ok;
    box_ready = 1'b0; num_row = 4'd1; num_col = 4'd2;
    load_std();
    pulse_done();
    wait_valid(ok);
    n_checks++;
    if (!ok) $display("FAIL stall_timeout got no box_valid exp box_valid within 100 cycles");
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if ({box_valid, box_idx, box_last, box_left, box_right, box_top, box_bottom} !==
          {1'b1, 4'd0, 1'b0, 11'd10, 11'd50, 11'd20, 11'd60})
        $display("FAIL stall_hold_%0d got v=%b idx=%0d last=%b L=%0d R=%0d exp 1,0,0,10,50",
                 i, box_valid, box_idx, box_last, box_left, box_right);
      else n_pass++;
    end
    box_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({box_valid, box_idx, box_last, box_left, box_right} !== {1'b1, 4'd1, 1'b1, 11'd70, 11'd110})
      $display("FAIL stall_box1 got v=%b idx=%0d last=%b L=%0d R=%0d exp 1,1,1,70,110",
               box_valid, box_idx, box_last, box_left, box_right);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({box_valid, busy} !== 2'b00)
      $display("FAIL stall_end got v=%b busy=%b exp 0,0", box_valid, busy);
    else n_pass++;
  endtask

  task automatic test_clamp;
    bit ok;
    logic [10:0] wrap = 11'd2046;
    row_mem[1] = 10'd300; row_mem[2] = 10'd280;
    col_mem[1] = wrap[9:0]; col_mem[2] = 10'd600;
    col_mem[3] = 10'd100;   col_mem[4] = 10'd40;
    box_ready = 1'b1; num_row = 4'd1; num_col = 4'd2;
    pulse_done();
    wait_valid(ok);
    n_checks++;
    if ({ok, box_idx, box_left, box_right, box_top, box_bottom} !== {1'b1, 4'd0, 11'd0, 11'd479, 11'd0, 11'd271})
      $display("FAIL clamp_box0 got ok=%b idx=%0d L=%0d R=%0d T=%0d B=%0d exp 1,0,0,479,0,271",
               ok, box_idx, box_left, box_right, box_top, box_bottom);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({box_valid, box_last, box_left, box_right, box_top, box_bottom} !== {1'b1, 1'b1, 11'd100, 11'd100, 11'd0, 11'd271})
      $display("FAIL clamp_box1 got v=%b last=%b L=%0d R=%0d T=%0d B=%0d exp 1,1,100,100,0,271",
               box_valid, box_last, box_left, box_right, box_top, box_bottom);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_limits;
    bit ok;
    int c0, s0, o0, r0, seen;
    logic [10:0] el [4] = '{11'd10, 11'd70, 11'd130, 11'd190};
    logic [10:0] er [4] = '{11'd50, 11'd110, 11'd170, 11'd230};
    load_std();
    col_mem[5] = 10'd130; col_mem[6] = 10'd170; col_mem[7] = 10'd190; col_mem[8] = 10'd230;
    col_mem[9] = 10'd300; col_mem[10] = 10'd310;
    box_ready = 1'b1; num_row = 4'd2; num_col = 4'd9;
    c0 = col_rd_cnt; s0 = col_addr_sum; o0 = col_over; r0 = row_rd_cnt;
    pulse_done();
    wait_valid(ok);
    n_checks++;
    if (!ok) $display("FAIL limit_timeout got no box_valid exp box_valid within 100 cycles");
    else n_pass++;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clk);
      n_checks++;
      if ({box_valid, box_idx, box_last, box_left, box_right, box_top, box_bottom} !==
          {1'b1, 4'(b), (b == 3), el[b], er[b], 11'd20, 11'd60})
        $display("FAIL limit_box%0d got v=%b idx=%0d last=%b L=%0d R=%0d exp 1,%0d,%0d,%0d,%0d",
                 b, box_valid, box_idx, box_last, box_left, box_right, b, (b == 3), el[b], er[b]);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({box_valid, busy} !== 2'b00) $display("FAIL limit_end got v=%b busy=%b exp 0,0", box_valid, busy);
    else n_pass++;
    n_checks++;
    if ((col_rd_cnt - c0 != 8) || (col_addr_sum - s0 != 36) || (col_over - o0 != 0) || (row_rd_cnt - r0 != 2))
      $display("FAIL limit_reads got col=%0d sum=%0d over=%0d row=%0d exp 8,36,0,2",
               col_rd_cnt - c0, col_addr_sum - s0, col_over - o0, row_rd_cnt - r0);
    else n_pass++;
    num_row = 4'd1; num_col = 4'd0;
    c0 = col_rd_cnt; r0 = row_rd_cnt; seen = 0;
    pulse_done();
    @(negedge clk);
    n_checks++;
    if ({busy, borders_valid} !== 2'b10)
      $display("FAIL zero_busy got busy=%b bv=%b exp 1,0", busy, borders_valid);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (box_valid) seen++;
    end
    n_checks++;
    if ({seen != 0, borders_valid, busy} !== 3'b000 || (col_rd_cnt != c0) || (row_rd_cnt != r0))
      $display("FAIL zero_cols got valid_cycles=%0d bv=%b busy=%b reads=%0d/%0d exp 0,0,0,0/0",
               seen, borders_valid, busy, col_rd_cnt - c0, row_rd_cnt - r0);
    else n_pass++;
  endtask

  task automatic test_restart;
    bit ok;
    int seen;
    load_std();
    box_ready = 1'b0; num_row = 4'd1; num_col = 4'd2;
    pulse_done();
    wait_valid(ok);
    pulse_done();
    @(negedge clk);
    n_checks++;
    if ({ok, box_valid, box_idx} !== {1'b1, 1'b1, 4'd0})
      $display("FAIL emit_redone got ok=%b v=%b idx=%0d exp 1,1,0", ok, box_valid, box_idx);
    else n_pass++;
    box_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({box_valid, box_idx, box_last} !== {1'b1, 4'd1, 1'b1})
      $display("FAIL emit_redone_box1 got v=%b idx=%0d last=%b exp 1,1,1", box_valid, box_idx, box_last);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (box_valid || busy) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL emit_redone_ignored got %0d active cycles exp 0", seen);
    else n_pass++;
    pulse_done();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (col_border_addr_rd != 10'd0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) $display("FAIL rdcol_timeout got no col read exp col read within 50 cycles");
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({box_valid, busy, borders_valid, on_border, box_last, col_border_addr_rd, row_border_addr_rd, box_left} !== 36'd0)
      $display("FAIL midreset got v=%b busy=%b bv=%b ob=%b caddr=%0d exp all 0",
               box_valid, busy, borders_valid, on_border, col_border_addr_rd);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_done();
    wait_valid(ok);
    n_checks++;
    if ({ok, box_idx, box_left, box_right, box_top, box_bottom} !== {1'b1, 4'd0, 11'd10, 11'd50, 11'd20, 11'd60})
      $display("FAIL restart_box0 got ok=%b idx=%0d L=%0d R=%0d T=%0d B=%0d exp 1,0,10,50,20,60",
               ok, box_idx, box_left, box_right, box_top, box_bottom);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({box_valid, box_idx, box_last, box_left, box_right} !== {1'b1, 4'd1, 1'b1, 11'd70, 11'd110})
      $display("FAIL restart_box1 got v=%b idx=%0d last=%b L=%0d R=%0d exp 1,1,1,70,110",
               box_valid, box_idx, box_last, box_left, box_right);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      row_mem[i] = 10'd0;
      col_mem[i] = 10'd0;
    end
    rst_n = 1'b0; project_done_flag = 1'b0; num_col = 4'd0; num_row = 4'd0;
    box_ready = 1'b0; xpos = 11'd0; ypos = 11'd0;
    test_reset();
    test_capture();
    test_overlay();
    test_stall();
    test_clamp();
    test_limits();
    test_restart();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
